// File: rtl/shift_normalizer_pkg.sv
// shift_normalizer_pkg: shared types and default sizing for the iterative
// left-normalizer.
//   state_e   : FSM encoding (IDLE accepts, SHIFT normalizes, DONE presents)
//   WIDTH_DEF : default data width
//   CW_DEF    : default shift-count width, $clog2(WIDTH_DEF)
package shift_normalizer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CW_DEF    = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_normalizer.sv
// shift_normalizer: shifts a word left one bit per cycle until its MSB is 1.
// Returns the normalized word and the shift count n, so that
// (out_data >> out_n) == in_data and n is the leading-zero count.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake (ready only in IDLE)
//   in_data  [WIDTH]      : word to normalize
//   out_valid/out_ready   : output handshake (valid only in DONE)
//   out_data [WIDTH]      : normalized word, MSB=1 unless input was zero
//   out_n    [CW]         : number of left shifts applied
//   out_zero              : input was all zeros
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_n,
  output logic             out_zero
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= '0;
            zero_q  <= (in_data == '0);
            // Zero and already-normalized words skip SHIFT entirely.
            state_q <= ((in_data == '0) || in_data[WIDTH-1]) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          data_q <= {data_q[WIDTH-2:0], 1'b0};
          cnt_q  <= cnt_q + 1'b1;
          // Finish on the edge that moves the first 1 into the MSB; a nonzero
          // word guarantees this within WIDTH-1 shifts, so cnt_q cannot wrap.
          if (data_q[WIDTH-2]) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags come from the state register; rst masks in_ready so no
  // word appears accepted during a reset cycle.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_n     = cnt_q;
  assign out_zero  = zero_q;

endmodule
